// File: rtl/ahb_reg_slave.sv
// AHB-Lite register-file slave: NUM_REGS x 32-bit registers, optional wait states, ERROR on bad access.
// Build option AHB_REG_SLAVE_BYTE_STROBE_EN enables byte/halfword writes; otherwise only word size is legal.
module ahb_reg_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           HSEL,
  input  logic [ADDR_WIDTH-1:0]          HADDR,
  input  logic [1:0]                     HTRANS,
  input  logic                           HWRITE,
  input  logic [2:0]                     HSIZE,
  input  logic [DATA_WIDTH-1:0]          HWDATA,
  input  logic                           HREADY,
  output logic                           HREADYOUT,
  output logic [1:0]                     HRESP,
  output logic [DATA_WIDTH-1:0]          HRDATA,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 2;
  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CntW    = 4;
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespError = 2'b01;

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e                state_q;
  logic                  hreadyout_q;
  logic [1:0]            hresp_q;
  logic [CntW-1:0]       wait_cnt_q;
  logic                  dp_valid_q;
  logic                  dp_write_q;
  logic [RegIdxW-1:0]    dp_idx_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  logic                  accept;
  logic                  in_range;
  logic                  size_ok;
  logic                  dp_done;
  logic [IdxW-1:0]       haddr_idx;
  logic [DATA_WIDTH-1:0] wr_word;

  assign haddr_idx = HADDR[ADDR_WIDTH-1:2];
  assign in_range  = 32'(haddr_idx) < NUM_REGS;
  // A new address phase is only taken while this slave is itself ready.
  assign accept    = HSEL & HTRANS[1] & HREADY & hreadyout_q;
  // OKAY data phase completes in the cycle it is seen from StIdle.
  assign dp_done   = (state_q == StIdle) & dp_valid_q;

`ifdef AHB_REG_SLAVE_BYTE_STROBE_EN
  logic [1:0] dp_lane_q;
  logic [2:0] dp_size_q;
  logic       unused_sigs;

  assign unused_sigs = HTRANS[0];
  assign size_ok     = HSIZE <= 3'b010;

  function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_w,
                                                       input logic [DATA_WIDTH-1:0] new_w,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            lane);
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    case (size)
      3'b000:  m[{lane, 3'b000} +: 8] = new_w[{lane, 3'b000} +: 8];
      3'b001:  m[{lane[1], 4'b0000} +: 16] = new_w[{lane[1], 4'b0000} +: 16];
      default: m = new_w;
    endcase
    return m;
  endfunction

  assign wr_word = merge_word(mem_q[dp_idx_q], HWDATA, dp_size_q, dp_lane_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_lane_q <= '0;
      dp_size_q <= '0;
    end else if (accept) begin
      dp_lane_q <= HADDR[1:0];
      dp_size_q <= HSIZE;
    end
  end
`else
  logic unused_sigs;

  assign unused_sigs = ^{HADDR[1:0], HTRANS[0]};
  assign size_ok     = HSIZE == 3'b010;
  assign wr_word     = HWDATA;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= RespOkay;
      wait_cnt_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_idx_q    <= '0;
      wr_pulse_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (dp_done && dp_write_q) begin
        mem_q[dp_idx_q]      <= wr_word;
        wr_pulse_q[dp_idx_q] <= 1'b1;
      end
      unique case (state_q)
        StIdle, StErr2: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= RespOkay;
          dp_valid_q  <= 1'b0;
          if (accept) begin
            dp_write_q <= HWRITE;
            dp_idx_q   <= haddr_idx[RegIdxW-1:0];
            if (!(in_range && size_ok)) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= RespError;
            end else if (WAIT_STATES == 0) begin
              dp_valid_q <= 1'b1;
            end else begin
              dp_valid_q  <= 1'b1;
              state_q     <= StWait;
              hreadyout_q <= 1'b0;
              wait_cnt_q  <= CntW'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = (dp_done && !dp_write_q) ? mem_q[dp_idx_q] : '0;
  assign wr_pulse  = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
  end

endmodule

// File: tb/tb_ahb_reg_slave.sv
// Directed bench for ahb_reg_slave: a zero-wait instance and a three-wait-state instance.
module tb_ahb_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic         rst_n, hsel, hwrite, hready, hreadyout;
  logic [11:0]  haddr;
  logic [1:0]   htrans, hresp;
  logic [2:0]   hsize;
  logic [31:0]  hwdata, hrdata;
  logic [255:0] regs;
  logic [7:0]   wrp;

  logic         rst1_n, hsel1, hwrite1, hready1, hreadyout1;
  logic [11:0]  haddr1;
  logic [1:0]   htrans1, hresp1;
  logic [2:0]   hsize1;
  logic [31:0]  hwdata1, hrdata1;
  logic [255:0] regs1;
  logic [7:0]   wrp1;

  logic [31:0]  reg0_exp;

  assign hready  = hreadyout;
  assign hready1 = hreadyout1;

  ahb_reg_slave #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut (
    .clk(clk), .rst_n(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .reg_q(regs), .wr_pulse(wrp)
  );

  ahb_reg_slave #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut_ws (
    .clk(clk), .rst_n(rst1_n), .HSEL(hsel1), .HADDR(haddr1), .HTRANS(htrans1), .HWRITE(hwrite1),
    .HSIZE(hsize1), .HWDATA(hwdata1), .HREADY(hready1), .HREADYOUT(hreadyout1), .HRESP(hresp1),
    .HRDATA(hrdata1), .reg_q(regs1), .wr_pulse(wrp1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%064h expected 0x%064h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic addr0(input logic wr, input logic [11:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
  endtask

  task automatic idle0;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic addr1(input logic wr, input logic [11:0] a, input logic [2:0] sz);
    hsel1 = 1'b1; htrans1 = 2'b10; hwrite1 = wr; haddr1 = a; hsize1 = sz;
  endtask

  task automatic idle1;
    hsel1 = 1'b0; htrans1 = 2'b00; hwrite1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    idle0; idle1;
    haddr = '0; hsize = 3'b010; hwdata = '0;
    haddr1 = '0; hsize1 = 3'b010; hwdata1 = '0;
    #12;
    check("rst hreadyout", 32'(hreadyout), 32'd1);
    check("rst hresp", 32'(hresp), 32'd0);
    check("rst hrdata", hrdata, 32'd0);
    check("rst wr_pulse", 32'(wrp), 32'd0);
    check_regs("rst regs", regs, '0);
    check("rst ws hreadyout", 32'(hreadyout1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; rst1_n = 1'b1;

    // Single write then read of register 1
    cyc; addr0(1'b1, 12'h004, 3'b010);
    cyc; idle0; hwdata = 32'hDEADBEEF;
    check("wr dphase ready", 32'(hreadyout), 32'd1);
    check("wr dphase no pulse", 32'(wrp), 32'd0);
    cyc;
    check("wr pulse reg1", 32'(wrp), 32'h02);
    check("reg1 written", regs[63:32], 32'hDEADBEEF);
    addr0(1'b0, 12'h004, 3'b010);
    cyc; idle0;
    check("rd ready", 32'(hreadyout), 32'd1);
    check("rd data", hrdata, 32'hDEADBEEF);
    check("rd resp", 32'(hresp), 32'd0);
    check("pulse one cycle", 32'(wrp), 32'd0);
    cyc;
    check("rd data cleared", hrdata, 32'd0);

    // Out-of-range write
    cyc; addr0(1'b1, 12'h020, 3'b010);
    cyc; idle0; hwdata = 32'h12345678;
    check("err1 ready", 32'(hreadyout), 32'd0);
    check("err1 resp", 32'(hresp), 32'd1);
    cyc;
    check("err2 ready", 32'(hreadyout), 32'd1);
    check("err2 resp", 32'(hresp), 32'd1);
    check("err2 no pulse", 32'(wrp), 32'd0);
    cyc;
    check("err idle resp", 32'(hresp), 32'd0);
    check("err no pulse", 32'(wrp), 32'd0);
    check_regs("err regs unchanged", regs, 256'h0000_0000_DEAD_BEEF_0000_0000);

    // Back-to-back writes to regs 0 and 1
    cyc; addr0(1'b1, 12'h000, 3'b010);
    cyc; addr0(1'b1, 12'h004, 3'b010); hwdata = 32'hA5A50001;
    check("b2b ready", 32'(hreadyout), 32'd1);
    cyc; idle0; hwdata = 32'h5A5A0002;
    check("b2b pulse reg0", 32'(wrp), 32'h01);
    check("b2b reg0", regs[31:0], 32'hA5A50001);
    cyc;
    check("b2b pulse reg1", 32'(wrp), 32'h02);
    check("b2b reg1", regs[63:32], 32'h5A5A0002);
    check("b2b reg0 kept", regs[31:0], 32'hA5A50001);

    // Write reg2 then read it on the very next transfer
    cyc; addr0(1'b1, 12'h008, 3'b010);
    cyc; addr0(1'b0, 12'h008, 3'b010); hwdata = 32'h0BADF00D;
    cyc; idle0;
    check("raw data", hrdata, 32'h0BADF00D);
    check("raw pulse", 32'(wrp), 32'h04);
    cyc;
    check("raw data cleared", hrdata, 32'd0);

    // HSEL=0 and BUSY transfers are ignored
    cyc; hsel = 1'b0; htrans = 2'b10; hwrite = 1'b1; haddr = 12'h000; hsize = 3'b010;
    cyc; hsel = 1'b1; htrans = 2'b01; hwdata = 32'hFFFFFFFF;
    check("nosel ready", 32'(hreadyout), 32'd1);
    check("nosel resp", 32'(hresp), 32'd0);
    cyc; idle0;
    check("busy ready", 32'(hreadyout), 32'd1);
    check("nosel no pulse", 32'(wrp), 32'd0);
    cyc;
    check("busy no pulse", 32'(wrp), 32'd0);
    check("ignored reg0", regs[31:0], 32'hA5A50001);

    // Sub-word write to reg0
    cyc; addr0(1'b1, 12'h000, 3'b010);
    cyc; idle0; hwdata = 32'h11223344;
    cyc;
    check("reg0 preset", regs[31:0], 32'h11223344);
    addr0(1'b1, 12'h002, 3'b000);
    cyc; idle0; hwdata = 32'h00AA0000;
`ifdef AHB_REG_SLAVE_BYTE_STROBE_EN
    check("byte wr ready", 32'(hreadyout), 32'd1);
    check("byte wr resp", 32'(hresp), 32'd0);
    cyc;
    check("byte wr reg0", regs[31:0], 32'h11AA3344);
    check("byte wr pulse", 32'(wrp), 32'h01);
    addr0(1'b1, 12'h002, 3'b001);
    cyc; idle0; hwdata = 32'hBEEF0000;
    cyc;
    check("half wr reg0", regs[31:0], 32'hBEEF3344);
    reg0_exp = 32'hBEEF3344;
`else
    check("byte err1 ready", 32'(hreadyout), 32'd0);
    check("byte err1 resp", 32'(hresp), 32'd1);
    cyc;
    check("byte err2 ready", 32'(hreadyout), 32'd1);
    check("byte err2 resp", 32'(hresp), 32'd1);
    cyc;
    check("byte err reg0", regs[31:0], 32'h11223344);
    check("byte err no pulse", 32'(wrp), 32'd0);
    reg0_exp = 32'h11223344;
`endif

    // Doubleword size is illegal in every build
    cyc; addr0(1'b1, 12'h000, 3'b011);
    cyc; idle0; hwdata = 32'h0;
    check("size err1 ready", 32'(hreadyout), 32'd0);
    check("size err1 resp", 32'(hresp), 32'd1);
    cyc; cyc;
    check("size err reg0", regs[31:0], reg0_exp);
    check("size err no pulse", 32'(wrp), 32'd0);

    // Three wait states: write then read reg0
    cyc; addr1(1'b1, 12'h000, 3'b010);
    cyc; idle1; hwdata1 = 32'hCAFEF00D;
    check("ws wr wait1", 32'(hreadyout1), 32'd0);
    cyc; check("ws wr wait2", 32'(hreadyout1), 32'd0);
    cyc; check("ws wr wait3", 32'(hreadyout1), 32'd0);
    cyc;
    check("ws wr done ready", 32'(hreadyout1), 32'd1);
    check("ws wr done resp", 32'(hresp1), 32'd0);
    check("ws wr no early pulse", 32'(wrp1), 32'd0);
    cyc;
    check("ws wr pulse", 32'(wrp1), 32'h01);
    check("ws reg0", regs1[31:0], 32'hCAFEF00D);
    addr1(1'b0, 12'h000, 3'b010);
    cyc; idle1;
    check("ws rd wait1", 32'(hreadyout1), 32'd0);
    check("ws rd wait data", hrdata1, 32'd0);
    cyc; check("ws rd wait2", 32'(hreadyout1), 32'd0);
    cyc; check("ws rd wait3", 32'(hreadyout1), 32'd0);
    cyc;
    check("ws rd ready", 32'(hreadyout1), 32'd1);
    check("ws rd data", hrdata1, 32'hCAFEF00D);
    check("ws rd resp", 32'(hresp1), 32'd0);
    cyc;
    check("ws rd data cleared", hrdata1, 32'd0);

    // Reset pulse during the wait of a write to reg3
    addr1(1'b1, 12'h00C, 3'b010);
    cyc; idle1; hwdata1 = 32'h77777777;
    check("ws abort in wait", 32'(hreadyout1), 32'd0);
    cyc;
    rst1_n = 1'b0;
    #1;
    check("ws async rst ready", 32'(hreadyout1), 32'd1);
    check("ws async rst resp", 32'(hresp1), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    cyc;
    check("ws post rst ready", 32'(hreadyout1), 32'd1);
    check("ws post rst resp", 32'(hresp1), 32'd0);
    check("ws post rst no pulse", 32'(wrp1), 32'd0);
    cyc;
    check("ws abort reg3", regs1[127:96], 32'd0);
    check("ws abort no pulse", 32'(wrp1), 32'd0);
    check("ws rst reg0", regs1[31:0], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Interface
REQ-001 Parameter DATA_WIDTH, 32, HWDATA/HRDATA/register width; only 32 is supported.
REQ-002 Parameter NUM_REGS, 8, number of registers (1..64).
REQ-003 Parameter ADDR_WIDTH, 12, HADDR bits decoded.
REQ-004 Parameter WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15).
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  ADDR_WIDTH  byte address.
REQ-009 HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
REQ-010 HWRITE  in  1  1=write.
REQ-011 HSIZE  in  3  transfer size.
REQ-012 HWDATA  in  DATA_WIDTH  write data, data phase.
REQ-013 HREADY  in  1  bus-level ready (previous transfer done).
REQ-014 HREADYOUT  out  1  slave ready.
REQ-015 HRESP  out  2  00=OKAY, 01=ERROR.
REQ-016 HRDATA  out  DATA_WIDTH  read data.
REQ-017 reg_q  out  NUM_REGS*DATA_WIDTH  register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-018 wr_pulse  out  NUM_REGS  one-cycle strobe per register written.

Function
REQ-019 Address phase SHALL be accepted when HSEL & HTRANS[1] & HREADY are all 1 at a rising edge; HADDR, HWRITE and HSIZE are registered at that edge.
REQ-020 Register index SHALL be HADDR[ADDR_WIDTH-1:2]; index >= NUM_REGS is out of range.
REQ-021 FSM states SHALL be: IDLE, WAIT, ERR1, ERR2.
REQ-022 IDLE: HREADYOUT=1, HRESP=OKAY.
REQ-023 On a valid in-range accept: if WAIT_STATES=0, stay in IDLE and complete next cycle; otherwise go to WAIT for exactly WAIT_STATES cycles with HREADYOUT=0, then complete.
REQ-024 On an out-of-range accept (or an illegal size, REQ-036): go to ERR1 (HREADYOUT=0, HRESP=ERROR), then ERR2 (HREADYOUT=1, HRESP=ERROR), then IDLE.
REQ-025 A write SHALL commit HWDATA at the edge ending the OKAY data phase (HREADYOUT=1); wr_pulse[index] SHALL be 1 in the cycle following that edge.
REQ-026 Read data SHALL be driven on HRDATA while HREADYOUT=1 in the OKAY data phase; otherwise HRDATA=0.
REQ-027 An ERROR transfer SHALL not modify any register or assert wr_pulse.
REQ-028 Back-to-back: a new address phase SHALL be accepted in the same cycle the previous data phase completes; no bubble is inserted.
REQ-029 IDLE/BUSY transfers (HTRANS[1]=0) or HSEL=0 SHALL be ignored with a zero-wait OKAY response.
REQ-030 A read following a write to the same register on the next transfer SHALL return the new value.

Reset
REQ-031 On rst_n=0, asynchronously: FSM=IDLE, HREADYOUT=1, HRESP=OKAY, HRDATA=0, all registers=0, wr_pulse=0, wait counter=0.
REQ-032 Reset asserted mid-transfer SHALL abort it without a register update; the first cycle after release is IDLE.

Configuration
REQ-033 Macro AHB_REG_SLAVE_BYTE_STROBE_EN SHALL select sub-word write support.
REQ-034 Defined: HSIZE=000 writes the byte lane HADDR[1:0], and HSIZE=001 writes the halfword lane HADDR[1]; other lanes are preserved.
REQ-035 Defined: reads of any legal size return the full word.
REQ-036 Not defined: any HSIZE other than 010 SHALL take the ERROR path of REQ-024.

Verification
REQ-037 WAIT_STATES=0: write 0xDEADBEEF to 0x004, then read 0x004 -> HRDATA=0xDEADBEEF, wr_pulse[1] for one cycle, HREADYOUT never 0.
REQ-038 WAIT_STATES=3: read 0x000 -> HREADYOUT low exactly 3 cycles, then data with OKAY.
REQ-039 NUM_REGS=8: write 0x020 -> ERR1/ERR2 two-cycle ERROR, all reg_q unchanged, no wr_pulse.
REQ-040 Back-to-back writes to 0x000 and 0x004 -> both registers updated in consecutive cycles, no bubble.
REQ-041 With macro defined, reg0=0x11223344: byte write 0xAA at 0x002 -> reg0=0x11AA3344; without macro, same stimulus -> ERROR, reg0 unchanged.
REQ-042 rst_n pulsed during WAIT of a write -> reg unchanged, HREADYOUT=1 and HRESP=OKAY after release.
